vliw_reg_file: RTL and testbench

Shared integer register file that answers the register-read requests issued by every IXU lane and absorbs each lane's writeback. It owns 32 x XLEN architectural registers with x0 hardwired to zero. It resolves same-cycle write collisions between lanes. It generates the per-lane forwarding controls and data that the IXUs consume during their execute stage.

---
 rtl/vliw_reg_file_pkg.sv | 13 +
 rtl/vliw_reg_file_if.sv | 34 +++
 rtl/vliw_reg_file_wr_arb.sv | 34 +++
 rtl/vliw_reg_file.sv | 114 +++++++++++
 tb/tb_vliw_reg_file.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/vliw_reg_file_pkg.sv
// Shared constants and types for the VLIW integer register file.
// Package name: vliw_pkg.
package vliw_pkg;

   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_LANES  = 2;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]       word_t;

endpackage : vliw_pkg

// File: rtl/vliw_reg_file_if.sv
// Read / writeback / bypass bus between the IXU lanes and the register file.
// master = IXU side, slave = register file side.
interface vliw_reg_file_if
   import vliw_pkg::*;
   #(parameter int NUM_LANES = vliw_pkg::NUM_LANES)
   ();

   logic [NUM_LANES*REG_ADDR_W-1:0] rs1_addr;
   logic [NUM_LANES*REG_ADDR_W-1:0] rs2_addr;
   logic [NUM_LANES*XLEN-1:0]       rs1_data;
   logic [NUM_LANES*XLEN-1:0]       rs2_data;
   logic [NUM_LANES*REG_ADDR_W-1:0] wr_rd;
   logic [NUM_LANES*XLEN-1:0]       wr_data;
   logic [NUM_LANES-1:0]            wr_en;
   logic [NUM_LANES-1:0]            is_rs1_fwd;
   logic [NUM_LANES-1:0]            is_rs2_fwd;
   logic [NUM_LANES*XLEN-1:0]       rs1_fwd_data;
   logic [NUM_LANES*XLEN-1:0]       rs2_fwd_data;
   logic                            conflict_err;
   logic                            conflict_clr;

   modport master (
      output rs1_addr, rs2_addr, wr_rd, wr_data, wr_en, conflict_clr,
      input  rs1_data, rs2_data, is_rs1_fwd, is_rs2_fwd,
             rs1_fwd_data, rs2_fwd_data, conflict_err
   );

   modport slave (
      input  rs1_addr, rs2_addr, wr_rd, wr_data, wr_en, conflict_clr,
      output rs1_data, rs2_data, is_rs1_fwd, is_rs2_fwd,
             rs1_fwd_data, rs2_fwd_data, conflict_err
   );

endinterface : vliw_reg_file_if

// File: rtl/vliw_reg_file_wr_arb.sv
// Writeback arbiter for one register address: reports whether any lane
// writes it, the data of the highest-numbered writing lane, and whether
// more than one lane hit. Address 0 never hits.
module reg_file_wr_arb
   import vliw_pkg::*;
   #(parameter int NUM_LANES = vliw_pkg::NUM_LANES)
   (
   input  reg_addr_t                       addr,
   input  logic [NUM_LANES-1:0]            wr_en,
   input  logic [NUM_LANES*REG_ADDR_W-1:0] wr_rd,
   input  logic [NUM_LANES*XLEN-1:0]       wr_data,
   output logic                            hit,
   output word_t                           data,
   output logic                            multi
   );

   // Scan lanes low to high so the last (highest) matching lane owns data.
   always_comb begin
      hit   = 1'b0;
      data  = {XLEN{1'b0}};
      multi = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (wr_en[i] && (wr_rd[i*REG_ADDR_W +: REG_ADDR_W] == addr) &&
             (addr != {REG_ADDR_W{1'b0}})) begin
            multi = multi | hit;
            hit   = 1'b1;
            data  = wr_data[i*XLEN +: XLEN];
         end else begin
            multi = multi;
         end
      end
   end

endmodule : reg_file_wr_arb

// File: rtl/vliw_reg_file.sv
// Shared 32 x XLEN integer register file for the IXU lanes: combinational
// reads, highest-lane-wins writeback, sticky write-conflict flag.
// Optional same-cycle bypass outputs are built when REG_FILE_BYPASS_EN
// is defined; otherwise they are tied to zero.
module vliw_reg_file
   import vliw_pkg::*;
   #(parameter int NUM_LANES = vliw_pkg::NUM_LANES)
   (
   input  logic                  clk,
   input  logic                  rst,
   vliw_reg_file_if.slave        bus
   );

   word_t                     regs_r [NUM_REGS];
   logic                      conflict_err_r;
   logic  [NUM_REGS-1:1]      row_hit_s;
   logic  [NUM_REGS-1:1]      row_multi_s;
   word_t                     row_data_s [1:NUM_REGS-1];
   logic  [NUM_LANES*XLEN-1:0] rs1_data_s;
   logic  [NUM_LANES*XLEN-1:0] rs2_data_s;

   // One arbiter per writable row resolves that row's writeback.
   for (genvar r = 1; r < NUM_REGS; r++) begin : g_row
      reg_file_wr_arb #(.NUM_LANES(NUM_LANES)) u_row_arb (
         .addr    (reg_addr_t'(r)),
         .wr_en   (bus.wr_en),
         .wr_rd   (bus.wr_rd),
         .wr_data (bus.wr_data),
         .hit     (row_hit_s[r]),
         .data    (row_data_s[r]),
         .multi   (row_multi_s[r])
      );
   end

   // Array update and sticky conflict flag; a new conflict beats a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_r[r] <= {XLEN{1'b0}};
         end
         conflict_err_r <= 1'b0;
      end else begin
         regs_r[0] <= {XLEN{1'b0}};
         for (int r = 1; r < NUM_REGS; r++) begin
            if (row_hit_s[r]) begin
               regs_r[r] <= row_data_s[r];
            end else begin
               regs_r[r] <= regs_r[r];
            end
         end
         if (|row_multi_s) begin
            conflict_err_r <= 1'b1;
         end else if (bus.conflict_clr) begin
            conflict_err_r <= 1'b0;
         end else begin
            conflict_err_r <= conflict_err_r;
         end
      end
   end

   // Combinational reads straight from the array; x0 forced to zero.
   always_comb begin
      rs1_data_s = {(NUM_LANES*XLEN){1'b0}};
      rs2_data_s = {(NUM_LANES*XLEN){1'b0}};
      for (int l = 0; l < NUM_LANES; l++) begin
         if (bus.rs1_addr[l*REG_ADDR_W +: REG_ADDR_W] == {REG_ADDR_W{1'b0}}) begin
            rs1_data_s[l*XLEN +: XLEN] = {XLEN{1'b0}};
         end else begin
            rs1_data_s[l*XLEN +: XLEN] = regs_r[bus.rs1_addr[l*REG_ADDR_W +: REG_ADDR_W]];
         end
         if (bus.rs2_addr[l*REG_ADDR_W +: REG_ADDR_W] == {REG_ADDR_W{1'b0}}) begin
            rs2_data_s[l*XLEN +: XLEN] = {XLEN{1'b0}};
         end else begin
            rs2_data_s[l*XLEN +: XLEN] = regs_r[bus.rs2_addr[l*REG_ADDR_W +: REG_ADDR_W]];
         end
      end
   end

   assign bus.rs1_data     = rs1_data_s;
   assign bus.rs2_data     = rs2_data_s;
   assign bus.conflict_err = conflict_err_r;

`ifdef REG_FILE_BYPASS_EN
   logic [2*NUM_LANES-1:0] bypass_multi_unused;

   // Per read port, the winning same-cycle writer feeds the bypass.
   for (genvar l = 0; l < NUM_LANES; l++) begin : g_byp
      reg_file_wr_arb #(.NUM_LANES(NUM_LANES)) u_rs1_arb (
         .addr    (bus.rs1_addr[l*REG_ADDR_W +: REG_ADDR_W]),
         .wr_en   (bus.wr_en),
         .wr_rd   (bus.wr_rd),
         .wr_data (bus.wr_data),
         .hit     (bus.is_rs1_fwd[l]),
         .data    (bus.rs1_fwd_data[l*XLEN +: XLEN]),
         .multi   (bypass_multi_unused[2*l])
      );
      reg_file_wr_arb #(.NUM_LANES(NUM_LANES)) u_rs2_arb (
         .addr    (bus.rs2_addr[l*REG_ADDR_W +: REG_ADDR_W]),
         .wr_en   (bus.wr_en),
         .wr_rd   (bus.wr_rd),
         .wr_data (bus.wr_data),
         .hit     (bus.is_rs2_fwd[l]),
         .data    (bus.rs2_fwd_data[l*XLEN +: XLEN]),
         .multi   (bypass_multi_unused[2*l+1])
      );
   end
`else
   assign bus.is_rs1_fwd   = {NUM_LANES{1'b0}};
   assign bus.is_rs2_fwd   = {NUM_LANES{1'b0}};
   assign bus.rs1_fwd_data = {(NUM_LANES*XLEN){1'b0}};
   assign bus.rs2_fwd_data = {(NUM_LANES*XLEN){1'b0}};
`endif

endmodule : vliw_reg_file

// File: tb/tb_vliw_reg_file.sv
// Self-checking bench for vliw_reg_file: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural register-file model. Honours REG_FILE_BYPASS_EN.
module tb_vliw_reg_file;
   import vliw_pkg::*;

   localparam int NL = 2;

   logic clk;
   logic rst;
   logic checking;
   int   n_vec;
   int   n_bad;

   logic [31:0] mem [32];
   logic        merr;

   vliw_reg_file_if #(.NUM_LANES(NL)) bus ();

   vliw_reg_file #(.NUM_LANES(NL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s lane%0d @%0t: got %h, expected %h", name, lane, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : mem[a];
   endfunction

   // Highest lane writing address a this cycle wins the bypass.
   task automatic m_fwd(input logic [4:0] a, output logic hit, output logic [31:0] d);
      hit = 1'b0;
      d   = 32'd0;
      for (int i = 0; i < NL; i++) begin
         if (bus.wr_en[i] && bus.wr_rd[i*5 +: 5] == a && a != 5'd0) begin
            hit = 1'b1;
            d   = bus.wr_data[i*32 +: 32];
         end
      end
   endtask

   // Behavioural model update at each clock edge.
   always @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 32; r++) mem[r] = 32'd0;
         merr = 1'b0;
      end else begin
         logic coll;
         coll = 1'b0;
         for (int i = 0; i < NL; i++)
            for (int j = i + 1; j < NL; j++)
               if (bus.wr_en[i] && bus.wr_en[j] && bus.wr_rd[i*5 +: 5] == bus.wr_rd[j*5 +: 5]
                   && bus.wr_rd[i*5 +: 5] != 5'd0)
                  coll = 1'b1;
         for (int i = 0; i < NL; i++)
            if (bus.wr_en[i] && bus.wr_rd[i*5 +: 5] != 5'd0)
               mem[bus.wr_rd[i*5 +: 5]] = bus.wr_data[i*32 +: 32];
         if (coll) merr = 1'b1;
         else if (bus.conflict_clr) merr = 1'b0;
      end
   end

   // Compare every DUT output against the model away from the active edge.
   always @(negedge clk) begin
      if (checking) begin
         for (int l = 0; l < NL; l++) begin
            logic h1, h2;
            logic [31:0] d1, d2;
            chk("rs1_data", l, bus.rs1_data[l*32 +: 32], m_read(bus.rs1_addr[l*5 +: 5]));
            chk("rs2_data", l, bus.rs2_data[l*32 +: 32], m_read(bus.rs2_addr[l*5 +: 5]));
            m_fwd(bus.rs1_addr[l*5 +: 5], h1, d1);
            m_fwd(bus.rs2_addr[l*5 +: 5], h2, d2);
`ifndef REG_FILE_BYPASS_EN
            h1 = 1'b0; h2 = 1'b0; d1 = 32'd0; d2 = 32'd0;
`endif
            chk("is_rs1_fwd", l, {31'd0, bus.is_rs1_fwd[l]}, {31'd0, h1});
            chk("is_rs2_fwd", l, {31'd0, bus.is_rs2_fwd[l]}, {31'd0, h2});
            chk("rs1_fwd_data", l, bus.rs1_fwd_data[l*32 +: 32], d1);
            chk("rs2_fwd_data", l, bus.rs2_fwd_data[l*32 +: 32], d2);
         end
         chk("conflict_err", 0, {31'd0, bus.conflict_err}, {31'd0, merr});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wr_en        = '0;
      bus.wr_rd        = '0;
      bus.wr_data      = '0;
      bus.rs1_addr     = '0;
      bus.rs2_addr     = '0;
      bus.conflict_clr = 1'b0;
   endtask

   task automatic set_wr(input int lane, input logic [4:0] rd, input logic [31:0] d);
      bus.wr_en[lane]          = 1'b1;
      bus.wr_rd[lane*5 +: 5]   = rd;
      bus.wr_data[lane*32 +: 32] = d;
   endtask

   initial begin
      checking = 1'b0;
      n_vec = 0;
      n_bad = 0;
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
      checking = 1'b1;

      // x7 write, visible only next cycle
      idle(); set_wr(0, 5'd7, 32'hDEAD_BEEF); bus.rs1_addr[4:0] = 5'd7;
      @(negedge clk); chk("pin_x7_before", 0, bus.rs1_data[31:0], 32'd0);
      tick(); idle(); bus.rs1_addr[4:0] = 5'd7;
      @(negedge clk); chk("pin_x7_after", 0, bus.rs1_data[31:0], 32'hDEAD_BEEF);
      // reset together with a write: nothing survives
      tick(); rst = 1'b1; set_wr(1, 5'd7, 32'h0000_1234);
      tick(); rst = 1'b0; idle(); bus.rs1_addr[4:0] = 5'd7;
      @(negedge clk); chk("pin_x7_reset", 0, bus.rs1_data[31:0], 32'd0);
      chk("pin_err_reset", 0, {31'd0, bus.conflict_err}, 32'd0);

      // lane0 writes x3, lane1 reads it
      tick(); idle(); set_wr(0, 5'd3, 32'h0000_1234); bus.rs1_addr[9:5] = 5'd3;
      @(negedge clk); chk("pin_lat_old", 1, bus.rs1_data[63:32], 32'd0);
      tick(); idle(); bus.rs1_addr[9:5] = 5'd3;
      @(negedge clk); chk("pin_lat_new", 1, bus.rs1_data[63:32], 32'h0000_1234);

      // both lanes write x0
      tick(); idle(); set_wr(0, 5'd0, 32'hFFFF_FFFF); set_wr(1, 5'd0, 32'h0000_0001);
      tick(); idle();
      @(negedge clk); chk("pin_x0", 0, bus.rs1_data[31:0], 32'd0);
      chk("pin_x0_err", 0, {31'd0, bus.conflict_err}, 32'd0);

      // collision on x5, lane1 wins, sticky flag then clear
      tick(); idle(); set_wr(0, 5'd5, 32'h0000_AAAA); set_wr(1, 5'd5, 32'h0000_BBBB);
      tick(); idle(); bus.rs1_addr[4:0] = 5'd5;
      @(negedge clk); chk("pin_coll_data", 0, bus.rs1_data[31:0], 32'h0000_BBBB);
      chk("pin_coll_err", 0, {31'd0, bus.conflict_err}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         @(negedge clk); chk("pin_err_hold", 0, {31'd0, bus.conflict_err}, 32'd1);
      end
      tick(); bus.conflict_clr = 1'b1;
      tick(); bus.conflict_clr = 1'b0;
      @(negedge clk); chk("pin_err_clr", 0, {31'd0, bus.conflict_err}, 32'd0);

      // new conflict together with clear: set wins
      tick(); set_wr(0, 5'd6, 32'h1); set_wr(1, 5'd6, 32'h2); bus.conflict_clr = 1'b1;
      tick(); idle();
      @(negedge clk); chk("pin_set_dom", 0, {31'd0, bus.conflict_err}, 32'd1);
      tick(); bus.conflict_clr = 1'b1;
      tick(); idle();

      // bypass: x9 old 0x11, lane1 writes 0x55 while lane0 reads rs2=x9
      set_wr(0, 5'd9, 32'h0000_0011);
      tick(); idle(); set_wr(1, 5'd9, 32'h0000_0055); bus.rs2_addr[4:0] = 5'd9;
      @(negedge clk);
      chk("pin_byp_old", 0, bus.rs2_data[31:0], 32'h0000_0011);
`ifdef REG_FILE_BYPASS_EN
      chk("pin_byp_hit", 0, {31'd0, bus.is_rs2_fwd[0]}, 32'd1);
      chk("pin_byp_data", 0, bus.rs2_fwd_data[31:0], 32'h0000_0055);
`else
      chk("pin_byp_hit", 0, {31'd0, bus.is_rs2_fwd[0]}, 32'd0);
      chk("pin_byp_data", 0, bus.rs2_fwd_data[31:0], 32'd0);
`endif

      // randomized traffic on a narrow address range to force collisions
      for (int c = 0; c < 600; c++) begin
         tick();
         rst = ($urandom_range(0, 59) == 0);
         bus.conflict_clr = ($urandom_range(0, 3) == 0);
         for (int l = 0; l < NL; l++) begin
            bus.wr_en[l]            = ($urandom_range(0, 3) != 0);
            bus.wr_rd[l*5 +: 5]     = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                                                  : 5'($urandom_range(0, 7));
            bus.wr_data[l*32 +: 32] = $urandom;
            bus.rs1_addr[l*5 +: 5]  = 5'($urandom_range(0, 7));
            bus.rs2_addr[l*5 +: 5]  = 5'($urandom_range(0, 31));
         end
      end
      tick();
      rst = 1'b0;
      idle();
      tick();
      @(negedge clk);
      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_vliw_reg_file
